// File: rtl/cla_multiword_add_sequencer_if.sv
// Handshake/bus bundle for cla_multiword_add_sequencer.
//   start_valid/start_ready : operand handshake carrying A, B, carryin
//   done_valid/done_ready   : result handshake carrying result, carryout
//   busy                    : sequencer is in RUN or DONE
// slave modport is the sequencer side, master modport is the producer/consumer side.
interface cla_multiword_add_sequencer_if #(
    parameter int NUMBITS  = 4,
    parameter int NUMWORDS = 8
);
    localparam int W = NUMBITS * NUMWORDS;

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         carryin;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] result;
    logic         carryout;
    logic         busy;

    modport slave (
        input  start_valid, A, B, carryin, done_ready,
        output start_ready, done_valid, result, carryout, busy
    );

    modport master (
        output start_valid, A, B, carryin, done_ready,
        input  start_ready, done_valid, result, carryout, busy
    );
endinterface

// File: rtl/cla_multiword_add_sequencer.sv
// Multi-cycle wide adder built around one external NUMBITS-wide adder slice.
// One operand word per RUN cycle is presented to the slice; the slice carry-out
// is registered and becomes the carry-in of the next word.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   bus         : operand/result handshakes (see cla_multiword_add_sequencer_if)
//   add_a/add_b/add_cin       : operand word and carry to the external adder slice
//   add_result/add_cout       : combinational sum and carry back from the slice
module cla_multiword_add_sequencer #(
    parameter int NUMBITS  = 4,
    parameter int NUMWORDS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    cla_multiword_add_sequencer_if.slave bus,
    output logic [NUMBITS-1:0]   add_a,
    output logic [NUMBITS-1:0]   add_b,
    output logic                 add_cin,
    input  logic [NUMBITS-1:0]   add_result,
    input  logic                 add_cout
);
    localparam int W  = NUMBITS * NUMWORDS;
    localparam int IW = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUMWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic          carry_q;
    logic [W-1:0]  result_q;
    logic          carryout_q;
    logic [31:0]   offs;

    // Bit offset of the word currently being added.
    assign offs = 32'(idx_q) * 32'(NUMBITS);

    assign bus.start_ready = (state_q == IDLE);
    assign bus.done_valid  = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.result      = result_q;
    assign bus.carryout    = carryout_q;

    // Slice inputs are only non-zero while a word is in flight.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[offs +: NUMBITS];
            add_b   = b_q[offs +: NUMBITS];
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            carryout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid) begin
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        carry_q  <= bus.carryin;
                        idx_q    <= '0;
                        result_q <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result_q[offs +: NUMBITS] <= add_result;
                    carry_q                   <= add_cout;
                    if (idx_q == LAST) begin
                        carryout_q <= add_cout;
                        idx_q      <= '0;
                        state_q    <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.done_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_multiword_add_sequencer.sv
module tb_cla_multiword_add_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Main instance: NUMBITS=4, NUMWORDS=8
    cla_multiword_add_sequencer_if #(.NUMBITS(4), .NUMWORDS(8)) u_if ();
    logic [3:0] a8_a, a8_b, a8_res;
    logic       a8_cin, a8_cout;
    always_comb {a8_cout, a8_res} = {1'b0, a8_a} + {1'b0, a8_b} + {4'b0, a8_cin};

    cla_multiword_add_sequencer #(.NUMBITS(4), .NUMWORDS(8)) u_dut8 (
        .clk(clk), .reset(reset), .bus(u_if.slave),
        .add_a(a8_a), .add_b(a8_b), .add_cin(a8_cin),
        .add_result(a8_res), .add_cout(a8_cout)
    );

    // Single-word instance: NUMBITS=4, NUMWORDS=1
    cla_multiword_add_sequencer_if #(.NUMBITS(4), .NUMWORDS(1)) u_if1 ();
    logic [3:0] a1_a, a1_b, a1_res;
    logic       a1_cin, a1_cout;
    always_comb {a1_cout, a1_res} = {1'b0, a1_a} + {1'b0, a1_b} + {4'b0, a1_cin};

    cla_multiword_add_sequencer #(.NUMBITS(4), .NUMWORDS(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(u_if1.slave),
        .add_a(a1_a), .add_b(a1_b), .add_cin(a1_cin),
        .add_result(a1_res), .add_cout(a1_cout)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic.
    function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {32'b0, c};
    endfunction

    // Drive one operation on the 8-word instance; returns sum, carry, latency, accept cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                          output logic [31:0] res, output logic cout,
                          output int lat, output int acc);
        int n;
        n = 0;
        while (!u_if.start_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("start_ready_wait", u_if.start_ready, 1);
        u_if.A = a; u_if.B = b; u_if.carryin = c; u_if.start_valid = 1'b1;
        @(negedge clk);
        acc = cyc;
        u_if.start_valid = 1'b0;
        check("run_word0_add_a", a8_a, a[3:0]);
        check("run_word0_add_b", a8_b, b[3:0]);
        check("run_word0_add_cin", a8_cin, c);
        lat = 0;
        while (!u_if.done_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        res  = u_if.result;
        cout = u_if.carryout;
    endtask

    task automatic release_done();
        u_if.done_ready = 1'b1;
        @(negedge clk);
        u_if.done_ready = 1'b0;
        check("release_start_ready", u_if.start_ready, 1);
    endtask

    initial begin
        logic [31:0] res;
        logic        cout;
        int          lat, acc, prev_acc;
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] exp;
        logic [31:0] hold_res;
        logic        hold_cout;
        bit          seen;

        reset = 1'b1;
        u_if.start_valid = 1'b0; u_if.A = '0; u_if.B = '0; u_if.carryin = 1'b0; u_if.done_ready = 1'b0;
        u_if1.start_valid = 1'b0; u_if1.A = '0; u_if1.B = '0; u_if1.carryin = 1'b0; u_if1.done_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_start_ready", u_if.start_ready, 1);
        check("rst_done_valid", u_if.done_valid, 0);
        check("rst_busy", u_if.busy, 0);
        check("rst_result", u_if.result, 0);
        check("rst_carryout", u_if.carryout, 0);
        check("rst_add_a", {a8_a, a8_b, a8_cin}, 0);
        reset = 1'b0;
        @(negedge clk);

        // All-ones plus one: carry ripples through every word.
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, res, cout, lat, acc);
        check("t1_latency", lat, 8);
        check("t1_result", res, 32'h00000000);
        check("t1_carryout", cout, 1);
        check("t1_done_start_ready", u_if.start_ready, 0);
        check("t1_done_busy", u_if.busy, 1);
        check("t1_done_add_a", {a8_a, a8_b, a8_cin}, 0);
        release_done();
        check("t1_idle_hold_result", u_if.result, 32'h00000000);
        check("t1_idle_hold_carryout", u_if.carryout, 1);
        check("t1_idle_done_valid", u_if.done_valid, 0);

        run_op(32'h0, 32'h0, 1'b1, res, cout, lat, acc);
        check("t2a_result", res, 32'h00000001);
        check("t2a_carryout", cout, 0);
        release_done();
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b0, res, cout, lat, acc);
        check("t2b_result", res, 32'hACF13568);
        check("t2b_carryout", cout, 0);
        check("t2b_latency", lat, 8);

        // Stall in DONE, attempt a new start which must be ignored.
        release_done();
        run_op(32'h0F0F0F0F, 32'hF0F0F0F1, 1'b0, res, cout, lat, acc);
        check("t3_result", res, 32'h00000000);
        check("t3_carryout", cout, 1);
        hold_res = u_if.result;
        hold_cout = u_if.carryout;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                u_if.A = 32'h11111111; u_if.B = 32'h22222222; u_if.carryin = 1'b1; u_if.start_valid = 1'b1;
            end else begin
                u_if.start_valid = 1'b0;
            end
            @(negedge clk);
            check("t3_stall_done_valid", u_if.done_valid, 1);
            check("t3_stall_start_ready", u_if.start_ready, 0);
            check("t3_stall_result", u_if.result, hold_res);
            check("t3_stall_carryout", u_if.carryout, hold_cout);
        end
        u_if.start_valid = 1'b0;
        release_done();
        check("t3_ignored_busy", u_if.busy, 0);
        check("t3_ignored_result", u_if.result, hold_res);

        // Reset in the middle of RUN, after non-zero result/carryout.
        run_op(32'hFFFFFFFF, 32'h00000002, 1'b0, res, cout, lat, acc);
        check("t4_pre_result", res, 32'h00000001);
        check("t4_pre_carryout", cout, 1);
        release_done();
        u_if.A = 32'h5; u_if.B = 32'h6; u_if.carryin = 1'b0; u_if.start_valid = 1'b1;
        @(negedge clk);
        u_if.start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t4_pre_busy", u_if.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_start_ready", u_if.start_ready, 1);
        check("t4_busy", u_if.busy, 0);
        check("t4_result", u_if.result, 0);
        check("t4_carryout", u_if.carryout, 0);
        check("t4_add_a", {a8_a, a8_b, a8_cin}, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (u_if.done_valid) seen = 1'b1;
        end
        check("t4_no_done_valid", seen, 0);

        // Single-word instance.
        u_if1.A = 4'hF; u_if1.B = 4'h1; u_if1.carryin = 1'b0; u_if1.start_valid = 1'b1;
        @(negedge clk);
        u_if1.start_valid = 1'b0;
        lat = 0;
        while (!u_if1.done_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("t5_latency", lat, 1);
        check("t5_result", u_if1.result, 4'h0);
        check("t5_carryout", u_if1.carryout, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            ra = 32'($urandom_range(15));
            rb = 32'($urandom_range(15));
            rc = 1'($urandom_range(1));
            u_if1.A = ra[3:0]; u_if1.B = rb[3:0]; u_if1.carryin = rc; u_if1.start_valid = 1'b1;
            @(negedge clk);
            u_if1.start_valid = 1'b0;
            @(negedge clk);
            exp = ref_sum(ra, rb, rc);
            check("t5_rand_done_valid", u_if1.done_valid, 1);
            check("t5_rand_sum", {u_if1.carryout, u_if1.result}, exp[4:0]);
        end

        // Random back-to-back operations with done_ready held high.
        @(negedge clk);
        u_if.done_ready = 1'b1;
        prev_acc = 0;
        for (int k = 0; k < 500; k++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(1));
            if (k % 50 == 0) begin
                ra = 32'hFFFFFFFF;
                rb = (k % 100 == 0) ? 32'h0 : 32'hFFFFFFFF;
                rc = 1'b1;
            end
            run_op(ra, rb, rc, res, cout, lat, acc);
            exp = ref_sum(ra, rb, rc);
            check("t6_latency", lat, 8);
            check("t6_sum", {cout, res}, exp);
            if (k > 0) check("t6_interval", acc - prev_acc, 10);
            prev_acc = acc;
        end
        u_if.done_ready = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
